// File: rtl/dot_product_accumulator.sv
// rtl/dot_product_accumulator.sv - signed multiply-accumulate stage for one dot product
// Sums a programmed number of signed products and hands the result on via valid/ready.
module dot_product_accumulator #(
  parameter int RESULT_WIDTH = 32,
  parameter int ACC_WIDTH    = 40,
  parameter int LEN_WIDTH    = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [LEN_WIDTH-1:0]    len,
  output logic                    busy,
  input  logic                    prod_valid,
  output logic                    prod_ready,
  input  logic [RESULT_WIDTH-1:0] product,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ACC_WIDTH-1:0]    sum,
  output logic                    overflow,
  output logic [LEN_WIDTH-1:0]    count
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t                      state, state_next;
  logic signed [ACC_WIDTH-1:0] acc;
  logic signed [ACC_WIDTH-1:0] addend;
  logic signed [ACC_WIDTH-1:0] acc_sum;
  logic [LEN_WIDTH-1:0]        len_q;
  logic                        accept;
  logic                        last;
  logic                        step_ovf;

  assign addend   = ACC_WIDTH'($signed(product));
  assign acc_sum  = acc + addend;
  // Two same-signed addends producing an opposite-signed result means the sum wrapped.
  assign step_ovf = (acc[ACC_WIDTH-1] == addend[ACC_WIDTH-1]) &&
                    (acc_sum[ACC_WIDTH-1] != acc[ACC_WIDTH-1]);
  assign accept   = prod_valid && prod_ready;
  assign last     = (count == len_q - LEN_WIDTH'(1));

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    prod_ready = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = (len != '0) ? ACCUM : DONE;
      end
      ACCUM: begin
        busy       = 1'b1;
        prod_ready = 1'b1;
        if (prod_valid && last) state_next = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      acc      <= '0;
      count    <= '0;
      len_q    <= '0;
      sum      <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (start) begin
            acc      <= '0;
            count    <= '0;
            overflow <= 1'b0;
            len_q    <= len;
            if (len == '0) sum <= '0;
          end
        end
        ACCUM: begin
          if (accept) begin
            acc      <= acc_sum;
            count    <= count + LEN_WIDTH'(1);
            overflow <= overflow | step_ovf;
            if (last) sum <= acc_sum;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dot_product_accumulator.sv
// tb/tb_dot_product_accumulator.sv - randomized self-checking bench for dot_product_accumulator
// Expected sums come from integer arithmetic on the product list, wrapped to the accumulator width.
module tb_dot_product_accumulator;
  localparam int RW = 32;
  localparam int AW = 40;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [LW-1:0] len;
  logic          busy;
  logic          prod_valid;
  logic          prod_ready;
  logic [RW-1:0] product;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] sum;
  logic          overflow;
  logic [LW-1:0] count;

  logic          s_start;
  logic [LW-1:0] s_len;
  logic          s_busy;
  logic          s_pv;
  logic          s_pr;
  logic [RW-1:0] s_prod;
  logic          s_ov;
  logic          s_or;
  logic [31:0]   s_sum;
  logic          s_ovf;
  logic [LW-1:0] s_count;

  int checks = 0;
  int passed = 0;
  int prods[$];

  always #5 clk = ~clk;

  dot_product_accumulator #(.RESULT_WIDTH(RW), .ACC_WIDTH(AW), .LEN_WIDTH(LW)) u_dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy),
    .prod_valid(prod_valid), .prod_ready(prod_ready), .product(product),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
    .overflow(overflow), .count(count)
  );

  dot_product_accumulator #(.RESULT_WIDTH(RW), .ACC_WIDTH(32), .LEN_WIDTH(LW)) u_dut32 (
    .clk(clk), .rst(rst), .start(s_start), .len(s_len), .busy(s_busy),
    .prod_valid(s_pv), .prod_ready(s_pr), .product(s_prod),
    .out_valid(s_ov), .out_ready(s_or), .sum(s_sum),
    .overflow(s_ovf), .count(s_count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
  endtask

  function automatic longint wrap(input longint v, input int w);
    longint m;
    m = v & ((longint'(1) << w) - 1);
    if (m >= (longint'(1) << (w - 1))) m = m - (longint'(1) << w);
    return m;
  endfunction

  // Runs one dot product over prods[] with random valid gaps and output stalls.
  task automatic run_dot(input int gap_min, input int gap_max, input int stall_min,
                         input int stall_max, input bit poke_start);
    longint acc;
    longint t;
    longint mx;
    longint mn;
    bit     ovf;
    int     l;
    int     gaps;
    int     stalls;
    acc = 0;
    ovf = 1'b0;
    l   = prods.size();
    mx  = (longint'(1) << (AW - 1)) - 1;
    mn  = -(longint'(1) << (AW - 1));
    @(negedge clk);
    start = 1'b1;
    len   = LW'(l);
    @(negedge clk);
    start = 1'b0;
    len   = LW'($urandom);
    for (int i = 0; i < l; i++) begin
      t = acc + longint'(prods[i]);
      if (t > mx || t < mn) ovf = 1'b1;
      acc  = wrap(t, AW);
      gaps = $urandom_range(gap_max, gap_min);
      for (int g = 0; g < gaps; g++) begin
        check("gap_ready", 64'(prod_ready), 64'(1));
        check("gap_no_valid", 64'(out_valid), 64'(0));
        @(negedge clk);
      end
      prod_valid = 1'b1;
      product    = prods[i];
      if (poke_start && i > 0) begin
        start = 1'b1;
        len   = LW'(7);
      end
      check("accept_ready", 64'(prod_ready), 64'(1));
      @(negedge clk);
      prod_valid = 1'b0;
      start      = 1'b0;
      if (i < l - 1) check("early_valid", 64'(out_valid), 64'(0));
    end
    check("latency_valid", 64'(out_valid), 64'(1));
    check("done_not_ready", 64'(prod_ready), 64'(0));
    stalls = $urandom_range(stall_max, stall_min);
    for (int s = 0; s < stalls; s++) begin
      out_ready = 1'b0;
      start     = 1'(s % 2);
      len       = LW'(3);
      check("stall_valid", 64'(out_valid), 64'(1));
      check("stall_ready", 64'(prod_ready), 64'(0));
      check("stall_sum", 64'($signed(sum)), 64'(acc));
      @(negedge clk);
    end
    out_ready = 1'b1;
    start     = 1'b1;
    len       = LW'(3);
    check("done_sum", 64'($signed(sum)), 64'(acc));
    check("done_count", 64'(count), 64'(l));
    check("done_overflow", 64'(overflow), 64'(ovf));
    @(negedge clk);
    out_ready = 1'b0;
    start     = 1'b0;
    check("idle_busy", 64'(busy), 64'(0));
    check("idle_valid", 64'(out_valid), 64'(0));
    check("held_sum", 64'($signed(sum)), 64'(acc));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; len = '0; prod_valid = 1'b0; product = '0; out_ready = 1'b0;
    s_start = 1'b0; s_len = '0; s_pv = 1'b0; s_prod = '0; s_or = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_prod_ready", 64'(prod_ready), 64'(0));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_overflow", 64'(overflow), 64'(0));
    check("rst_sum", 64'(sum), 64'(0));
    check("rst_count", 64'(count), 64'(0));

    prods = '{131072, -131072, 375};
    run_dot(0, 0, 0, 0, 1'b0);

    prods.delete();
    run_dot(0, 0, 2, 2, 1'b0);

    prods = '{512, -30467460};
    run_dot(3, 3, 5, 5, 1'b0);

    // Abort a dot product halfway with a one-cycle reset.
    @(negedge clk);
    start = 1'b1;
    len   = LW'(4);
    @(negedge clk);
    start      = 1'b0;
    prod_valid = 1'b1;
    product    = RW'(100);
    repeat (2) @(negedge clk);
    prod_valid = 1'b0;
    rst        = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_count", 64'(count), 64'(0));
    check("abort_valid", 64'(out_valid), 64'(0));
    check("abort_sum", 64'(sum), 64'(0));
    prods = '{-30467460};
    run_dot(0, 0, 0, 0, 1'b0);

    prods = '{10, 20};
    run_dot(0, 1, 1, 1, 1'b1);

    for (int n = 0; n < 20; n++) begin
      int l;
      prods.delete();
      l = $urandom_range(6, 0);
      for (int k = 0; k < l; k++) prods.push_back(int'($urandom));
      run_dot(0, 2, 0, 3, 1'($urandom_range(1, 0)));
    end

    // 32-bit accumulator: positive overflow wraps to the most negative value.
    @(negedge clk);
    s_start = 1'b1;
    s_len   = LW'(2);
    @(negedge clk);
    s_start = 1'b0;
    s_pv    = 1'b1;
    s_prod  = 32'h7FFF_FFFF;
    @(negedge clk);
    s_prod = 32'h0000_0001;
    @(negedge clk);
    s_pv = 1'b0;
    check("ovf32_valid", 64'(s_ov), 64'(1));
    check("ovf32_flag", 64'(s_ovf), 64'(1));
    check("ovf32_sum", 64'(s_sum), 64'(32'h8000_0000));
    s_or = 1'b1;
    @(negedge clk);
    s_or    = 1'b0;
    s_start = 1'b1;
    s_len   = LW'(1);
    @(negedge clk);
    s_start = 1'b0;
    s_pv    = 1'b1;
    s_prod  = 32'd5;
    @(negedge clk);
    s_pv = 1'b0;
    check("ovf32_clear_valid", 64'(s_ov), 64'(1));
    check("ovf32_clear_flag", 64'(s_ovf), 64'(0));
    check("ovf32_clear_sum", 64'(s_sum), 64'(5));
    s_or = 1'b1;
    @(negedge clk);
    s_or = 1'b0;
    check("ovf32_idle", 64'(s_busy), 64'(0));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
